uart_tx_sched: RTL and testbench
================================

Name: uart_tx_sched

Overview:
- Shares one UART transmit line between NUM_REQ byte requesters.
- Round-robin arbitration with optional packet lock: a requester holds the line until it sends a byte flagged last.
- Serialises 8N1-style frames (configurable stop bits), advancing one symbol per externally supplied baud tick. The tick comes from the team's baud generator with OVERSAMPLE=1.
- Sits between the protocol/message blocks and the TX pin.

Parameters:
- NUM_REQ, 4, number of requesters; 2..16.
- DATA_W, 8, data bits per frame, sent LSB first.
- STOP_BITS, 1, stop bits per frame; 1 or 2.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- baud_tick  input  1  one-clk pulse per bit period, free-running
- req_valid  input  NUM_REQ  per-requester byte valid
- req_data  input  NUM_REQ*DATA_W  per-requester byte; requester i occupies bits [i*DATA_W +: DATA_W]
- req_last  input  NUM_REQ  byte ends packet; releases the lock
- req_ready  output  NUM_REQ  one-hot accept; handshake occurs when valid&ready
- tx  output  1  serial line, idle high
- busy  output  1  high from accept until the final stop bit ends
- grant_id  output  $clog2(NUM_REQ)  index of the last accepted requester
- locked  output  1  a packet is in progress

Behaviour:
- Reset values:
  - tx=1, busy=0, grant_id=0, locked=0, req_ready=0.
  - Round-robin pointer = NUM_REQ-1, so requester 0 has first priority.
  - State = IDLE.
- States: IDLE, WAIT_START, START, DATA, STOP.
- IDLE:
  - req_ready is combinational and asserted only in IDLE.
  - Unlocked: one-hot to the first valid requester searching from pointer+1 with wrap-around.
  - Locked: only the locked requester's bit may assert; all others wait even if valid.
  - On handshake:
    - Latch the byte into the shift register.
    - grant_id <= i, pointer <= i, busy <= 1.
    - locked <= ~req_last[i].
    - Go to WAIT_START.
  - No valid (or locked requester not valid): stay in IDLE, tx=1. There is no lock timeout.
- WAIT_START: on baud_tick, tx <= 0 and go to START. A tick in the same cycle as the accept is ignored, so the start bit always begins on a later tick.
- START: on baud_tick, tx <= shift[0], shift right, bit counter <= 1, go to DATA.
- DATA:
  - On baud_tick, if bit counter < DATA_W: tx <= shift[0], shift, increment counter.
  - Otherwise tx <= 1, stop counter <= 1, go to STOP.
- STOP:
  - On baud_tick, if stop counter < STOP_BITS: increment.
  - Otherwise go to IDLE with busy <= 0; tx stays 1.
  - Handshake is possible in that same IDLE cycle, so back-to-back frames have no extra idle bit period.
- Symbol timing: tx changes only on baud_tick cycles (registered). Every symbol lasts exactly one tick interval. Frame length = 1 + DATA_W + STOP_BITS ticks after WAIT_START.
- Accept-to-start latency: 1 to one full tick period plus 1 clk, because the free-running tick is not realigned.
- Asynchronous rst mid-frame:
  - tx returns to 1 immediately.
  - The in-flight byte is dropped and the lock is cleared.
  - The requester is not re-signalled.
- req_valid dropping without a handshake is legal; arbitration re-evaluates every IDLE cycle.
- Counters are sized $clog2(DATA_W+1) and 2 bits respectively. No wrap is possible because state exits before overflow.

Decomposition:
- Shared package uart_pkg holds:
  - state enum (IDLE, WAIT_START, START, DATA, STOP);
  - IDLE_LEVEL=1'b1 and START_LEVEL=1'b0;
  - a function computing frame length in ticks.
- One natural sub-module, rr_arbiter:
  - Inputs: request vector, pointer, lock enable, lock index.
  - Output: one-hot grant.
  - Purely combinational; the pointer register lives in uart_tx_sched.

Test Plan:
- Single byte: req_valid=0001, data=0xA5, last=1, tick every 16 clk -> tx bit sequence 0,1,0,1,0,0,1,0,1,1; busy high for exactly 10 ticks after start; locked=0; grant_id=0.
- Round-robin: all four valid with last=1 simultaneously -> accept order 0,1,2,3,0; frames back-to-back with no idle tick between the stop bit and the next start.
- Packet lock: requester 2 sends 0x11 (last=0) then 0x22 (last=1) while requester 0 is valid -> 2,2 served before 0; locked=1 between the two bytes; requester 0 is accepted next.
- Tick/accept collision: baud_tick pulses in the handshake cycle -> tx stays 1 on that tick; start bit appears on the following tick.
- Reset mid-frame: assert rst during DATA bit 4 -> tx=1, busy=0, locked=0, req_ready=0 in the same cycle; after release, requester 0 has first priority again.
- STOP_BITS=2 build: byte 0xFF -> tx low for 1 tick, then high for 10 ticks; busy clears after the 11th tick.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the scheduled UART transmitter.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_START,
      START,
      DATA,
      STOP
   } state_t;

   localparam logic IDLE_LEVEL  = 1'b1;
   localparam logic START_LEVEL = 1'b0;

   // Symbols on the line per frame: start bit, data bits, stop bits.
   function automatic int frame_ticks(input int data_w, input int stop_bits);
      return 1 + data_w + stop_bits;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter with an optional lock onto one requester.
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   pointer,
   input  logic               lock_en,
   input  logic [IDX_W-1:0]   lock_idx,
   output logic [NUM_REQ-1:0] grant
);

   int               sum;
   logic [IDX_W-1:0] idx;

   always_comb begin
      // NOTE: every variable gets a default before any branch so no latch is inferred.
      grant = '0;
      sum   = 0;
      idx   = '0;
      if (lock_en) begin
         grant[lock_idx] = req[lock_idx];
      end else begin
         // Walk from farthest to nearest so the nearest valid requester after pointer wins.
         for (int k = NUM_REQ; k >= 1; k--) begin
            sum = int'(pointer) + k;
            if (sum >= NUM_REQ) sum = sum - NUM_REQ;
            idx = IDX_W'(sum);
            if (req[idx]) grant = NUM_REQ'(1) << idx;
         end
      end
   end

endmodule

// File: rtl/uart_tx_sched.sv
// Shares one UART TX line among NUM_REQ byte sources with round-robin arbitration and packet lock.
module uart_tx_sched
   import uart_pkg::*;
#(
   parameter int NUM_REQ   = 4,
   parameter int DATA_W    = 8,
   parameter int STOP_BITS = 1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        baud_tick,
   input  logic [NUM_REQ-1:0]          req_valid,
   input  logic [NUM_REQ*DATA_W-1:0]   req_data,
   input  logic [NUM_REQ-1:0]          req_last,
   output logic [NUM_REQ-1:0]          req_ready,
   output logic                        tx,
   output logic                        busy,
   output logic [$clog2(NUM_REQ)-1:0]  grant_id,
   output logic                        locked
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(DATA_W + 1);

   state_t              state;
   state_t              state_next;
   logic [IDX_W-1:0]    pointer;
   logic [NUM_REQ-1:0]  grant;
   logic                accept;
   logic [IDX_W-1:0]    accept_idx;
   logic [DATA_W-1:0]   accept_data;
   logic                accept_last;
   logic [DATA_W-1:0]   shift;
   logic [CNT_W-1:0]    bit_cnt;
   logic [1:0]          stop_cnt;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_arb (
      .req      (req_valid),
      .pointer  (pointer),
      .lock_en  (locked),
      .lock_idx (grant_id),
      .grant    (grant)
   );

   // Ready is offered only while idle and never while reset is held.
   assign req_ready = (state == IDLE && !rst) ? grant : '0;
   assign accept    = |req_ready;

   always_comb begin
      accept_idx  = '0;
      accept_data = '0;
      accept_last = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            accept_idx  = IDX_W'(i);
            accept_data = req_data[i*DATA_W +: DATA_W];
            accept_last = req_last[i];
         end
      end
   end

   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:       if (accept)    state_next = WAIT_START;
         WAIT_START: if (baud_tick) state_next = START;
         START:      if (baud_tick) state_next = DATA;
         DATA:       if (baud_tick && bit_cnt >= CNT_W'(DATA_W))    state_next = STOP;
         STOP:       if (baud_tick && stop_cnt >= 2'(STOP_BITS))    state_next = IDLE;
         default:    state_next = IDLE;
      endcase
   end

   // NOTE: non-blocking assignments make every register sample pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx       <= IDLE_LEVEL;
         busy     <= 1'b0;
         grant_id <= '0;
         locked   <= 1'b0;
         pointer  <= IDX_W'(NUM_REQ - 1);
         // NOTE: the shift register is reset too so no X can ever reach the pin.
         shift    <= '0;
         bit_cnt  <= '0;
         stop_cnt <= '0;
      end else begin
         unique case (state)
            IDLE: if (accept) begin
               shift    <= accept_data;
               grant_id <= accept_idx;
               pointer  <= accept_idx;
               busy     <= 1'b1;
               locked   <= ~accept_last;
            end
            WAIT_START: if (baud_tick) tx <= START_LEVEL;
            START: if (baud_tick) begin
               tx      <= shift[0];
               shift   <= shift >> 1;
               bit_cnt <= CNT_W'(1);
            end
            DATA: if (baud_tick) begin
               if (bit_cnt < CNT_W'(DATA_W)) begin
                  tx      <= shift[0];
                  shift   <= shift >> 1;
                  bit_cnt <= bit_cnt + CNT_W'(1);
               end else begin
                  tx       <= IDLE_LEVEL;
                  stop_cnt <= 2'd1;
               end
            end
            STOP: if (baud_tick) begin
               if (stop_cnt < 2'(STOP_BITS)) stop_cnt <= stop_cnt + 2'd1;
               else                          busy     <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: a frame-level model compared every cycle plus directed literal checks.
`timescale 1ns/1ps
module tb_uart_tx_sched;
   import uart_pkg::*;

   localparam int NR = 4;
   localparam int DW = 8;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            baud_tick = 1'b0;
   logic [NR-1:0]   req_valid = '0;
   logic [NR-1:0]   req_last = '0;
   logic [NR*DW-1:0] req_data = '0;
   logic [NR-1:0]   req_ready;
   logic            tx, busy, locked;
   logic [1:0]      grant_id;

   logic [NR-1:0]   v2 = '0;
   logic [NR-1:0]   l2 = '0;
   logic [NR*DW-1:0] d2 = '0;
   logic [NR-1:0]   ready2;
   logic            tx2, busy2, locked2;
   logic [1:0]      gid2;

   int n_checks = 0;
   int n_fail   = 0;

   uart_tx_sched #(.NUM_REQ(NR), .DATA_W(DW), .STOP_BITS(1)) dut (
      .clk(clk), .rst(rst), .baud_tick(baud_tick),
      .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
      .req_ready(req_ready), .tx(tx), .busy(busy),
      .grant_id(grant_id), .locked(locked)
   );

   uart_tx_sched #(.NUM_REQ(NR), .DATA_W(DW), .STOP_BITS(2)) dut2 (
      .clk(clk), .rst(rst), .baud_tick(baud_tick),
      .req_valid(v2), .req_data(d2), .req_last(l2),
      .req_ready(ready2), .tx(tx2), .busy(busy2),
      .grant_id(gid2), .locked(locked2)
   );

   always #5 clk = ~clk;

   int tick_div = 0;
   initial forever begin
      @(posedge clk);
      #2;
      tick_div  = (tick_div == 15) ? 0 : tick_div + 1;
      baud_tick = (tick_div == 15);
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic timeout(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: wait bound expired, got no event expected one at %0t", name, $time);
   endtask

   // Model: arbitration by rule, frame as a list of line levels consumed one per tick.
   int m_ptr = NR - 1;
   int m_grant = 0;
   int m_ticks = 0;
   bit m_lock = 1'b0;
   bit m_busy = 1'b0;
   bit m_idle = 1'b1;
   bit m_tx   = 1'b1;
   bit m_levels[$];

   function automatic int pick(input logic [NR-1:0] v);
      if (m_lock) return v[m_grant] ? m_grant : -1;
      for (int k = 1; k <= NR; k++)
         if (v[(m_ptr + k) % NR]) return (m_ptr + k) % NR;
      return -1;
   endfunction

   initial forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
         m_ptr = NR - 1; m_grant = 0; m_lock = 0;
         m_busy = 0; m_idle = 1; m_tx = 1; m_ticks = 0;
      end else if (m_idle) begin : accept_blk
         int g;
         logic [DW-1:0] b;
         g = pick(req_valid);
         if (g >= 0) begin
            b = req_data[g*DW +: DW];
            m_levels.delete();
            m_levels.push_back(1'b0);
            for (int j = 0; j < DW; j++) m_levels.push_back(b[j]);
            while (m_levels.size() < frame_ticks(DW, 1)) m_levels.push_back(1'b1);
            m_idle = 0; m_busy = 1; m_ticks = 0;
            m_grant = g; m_ptr = g; m_lock = !req_last[g];
         end
      end else if (baud_tick) begin
         m_ticks++;
         if (m_ticks <= m_levels.size()) m_tx = m_levels[m_ticks-1];
         else begin
            m_idle = 1;
            m_busy = 0;
         end
      end
   end

   initial forever begin
      @(negedge clk);
      begin : cmp_blk
         logic [NR-1:0] er;
         int g;
         er = '0;
         if (!rst && m_idle) begin
            g = pick(req_valid);
            if (g >= 0) er[g] = 1'b1;
         end
         check("model_req_ready", req_ready, er);
         check("model_tx", tx, m_tx);
         check("model_busy", busy, m_busy);
         check("model_grant_id", grant_id, m_grant);
         check("model_locked", locked, m_lock);
      end
   end

   logic [DW-1:0] q_data[NR][$];
   bit            q_last[NR][$];
   int            acc_log[$];
   bit            lock_log[$];

   task automatic apply_fronts();
      for (int i = 0; i < NR; i++) begin
         if (q_data[i].size() > 0) begin
            req_valid[i] = 1'b1;
            req_data[i*DW +: DW] = q_data[i][0];
            req_last[i] = q_last[i][0];
         end else begin
            req_valid[i] = 1'b0;
            req_data[i*DW +: DW] = '0;
            req_last[i] = 1'b0;
         end
      end
   endtask

   task automatic run_queues(input int budget, input bit wait_idle);
      int cyc;
      bit pend;
      bit done;
      int left;
      cyc = 0;
      pend = 0;
      apply_fronts();
      forever begin
         @(negedge clk);
         if (pend) begin
            lock_log.push_back(locked);
            pend = 0;
         end
         for (int i = 0; i < NR; i++) begin
            if (req_valid[i] && req_ready[i]) begin
               acc_log.push_back(i);
               void'(q_data[i].pop_front());
               void'(q_last[i].pop_front());
               pend = 1;
            end
         end
         left = 0;
         for (int i = 0; i < NR; i++) left += q_data[i].size();
         done = !pend && left == 0 && (!wait_idle || m_idle);
         if (done) break;
         cyc++;
         if (cyc > budget) begin
            timeout("run_queues");
            break;
         end
         @(posedge clk);
         #2;
         apply_fronts();
      end
      @(posedge clk);
      #2;
   endtask

   task automatic wait_tick();
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!baud_tick && n < 40);
      if (!baud_tick) timeout("wait_tick");
      @(negedge clk);
   endtask

   task automatic wait_hs(input bit second, input int i);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(second ? ready2[i] : req_ready[i]) && n < 100);
      if (!(second ? ready2[i] : req_ready[i])) timeout("handshake");
      @(posedge clk);
      #2;
   endtask

   task automatic wait_model_idle(input int budget);
      int n;
      n = 0;
      while (!m_idle && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (!m_idle) timeout("wait_idle");
      @(posedge clk);
      #2;
   endtask

   int exp_rr[5]   = '{0, 1, 2, 3, 0};
   int exp_lock[3] = '{2, 2, 0};
   bit exp_lk[3]   = '{1'b1, 1'b0, 1'b0};
   bit a5_bits[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

   initial begin
      // Reset values, with requesters valid to show ready is held low.
      req_valid = '1;
      @(negedge clk);
      check("rst_tx", tx, 1);
      check("rst_busy", busy, 0);
      check("rst_grant_id", grant_id, 0);
      check("rst_locked", locked, 0);
      check("rst_req_ready", req_ready, 0);
      @(posedge clk);
      #2;
      req_valid = '0;
      rst = 1'b0;

      // Round-robin: all four valid, requester 0 has a second byte.
      q_data[0].push_back(8'hA0); q_last[0].push_back(1'b1);
      q_data[0].push_back(8'hA4); q_last[0].push_back(1'b1);
      q_data[1].push_back(8'hA1); q_last[1].push_back(1'b1);
      q_data[2].push_back(8'hA2); q_last[2].push_back(1'b1);
      q_data[3].push_back(8'hA3); q_last[3].push_back(1'b1);
      acc_log.delete();
      run_queues(3000, 1'b1);
      check("rr_count", acc_log.size(), 5);
      for (int k = 0; k < 5 && k < acc_log.size(); k++) check("rr_order", acc_log[k], exp_rr[k]);

      // Single byte 0xA5 from requester 0, sampled one tick at a time.
      req_valid = 4'b0001;
      req_data[7:0] = 8'hA5;
      req_last = 4'b0001;
      wait_hs(1'b0, 0);
      req_valid = '0;
      check("a5_grant_id", grant_id, 0);
      check("a5_locked", locked, 0);
      check("a5_busy_start", busy, 1);
      for (int k = 0; k < 10; k++) begin
         wait_tick();
         check("a5_bit", tx, a5_bits[k]);
         check("a5_busy", busy, 1);
      end
      wait_tick();
      check("a5_busy_end", busy, 0);
      check("a5_tx_idle", tx, 1);
      @(posedge clk);
      #2;

      // Packet lock: requester 2 sends two bytes before requester 0 is served.
      q_data[2].push_back(8'h11); q_last[2].push_back(1'b0);
      q_data[2].push_back(8'h22); q_last[2].push_back(1'b1);
      q_data[0].push_back(8'h33); q_last[0].push_back(1'b1);
      acc_log.delete();
      lock_log.delete();
      run_queues(3000, 1'b1);
      check("lock_count", acc_log.size(), 3);
      for (int k = 0; k < 3 && k < acc_log.size(); k++) check("lock_order", acc_log[k], exp_lock[k]);
      for (int k = 0; k < 3 && k < lock_log.size(); k++) check("lock_flag", lock_log[k], exp_lk[k]);

      // Tick in the accept cycle is ignored; start bit waits for the next tick.
      @(posedge baud_tick);
      req_valid = 4'b1000;
      req_data[31:24] = 8'h0F;
      req_last = 4'b1000;
      @(negedge clk);
      check("coll_ready", req_ready, 4'b1000);
      @(posedge clk);
      #2;
      req_valid = '0;
      @(negedge clk);
      check("coll_tx_held", tx, 1);
      check("coll_busy", busy, 1);
      check("coll_grant_id", grant_id, 3);
      wait_tick();
      check("coll_start_bit", tx, 0);
      wait_model_idle(400);

      // Reset in the middle of the data bits, then priority restarts at requester 0.
      q_data[1].push_back(8'h5A); q_last[1].push_back(1'b0);
      acc_log.delete();
      run_queues(200, 1'b0);
      begin : wait_bit4
         int n;
         n = 0;
         while (m_ticks < 6 && n < 300) begin
            @(negedge clk);
            n++;
         end
         if (m_ticks < 6) timeout("wait_data_bit4");
      end
      @(posedge clk);
      #2;
      check("pre_rst_locked", locked, 1);
      check("pre_rst_busy", busy, 1);
      rst = 1'b1;
      req_valid = 4'b1001;
      #1;
      check("mid_rst_tx", tx, 1);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_locked", locked, 0);
      check("mid_rst_req_ready", req_ready, 0);
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b0;
      q_data[0].push_back(8'h3C); q_last[0].push_back(1'b1);
      q_data[3].push_back(8'hC3); q_last[3].push_back(1'b1);
      acc_log.delete();
      run_queues(3000, 1'b1);
      check("post_rst_count", acc_log.size(), 2);
      if (acc_log.size() >= 2) begin
         check("post_rst_first", acc_log[0], 0);
         check("post_rst_second", acc_log[1], 3);
      end

      // Two stop bits: 0xFF is one low symbol then ten high symbols.
      v2 = 4'b0001;
      d2[7:0] = 8'hFF;
      l2 = 4'b0001;
      wait_hs(1'b1, 0);
      v2 = '0;
      for (int k = 1; k <= 11; k++) begin
         wait_tick();
         check("sb2_tx", tx2, (k == 1) ? 0 : 1);
         check("sb2_busy", busy2, 1);
      end
      wait_tick();
      check("sb2_busy_end", busy2, 0);
      check("sb2_tx_idle", tx2, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
